pci_arbiter: RTL and testbench

PCI_ARBITER -- requirements
Module: pci_arbiter

---
 rtl/pci_arb_pkg.sv | 15 +
 rtl/rr_picker.sv | 30 +++
 rtl/pci_arbiter.sv | 143 ++++++++++++++
 tb/tb_pci_arbiter.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/pci_arb_pkg.sv
// Shared types and constants for the PCI bus arbiter.
package pci_arb_pkg;

  localparam int unsigned MAX_DEV         = 8;
  localparam int unsigned OWNER_W         = $clog2(MAX_DEV);
  localparam int unsigned DEF_GNT_TIMEOUT = 16;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_GRANTED    = 2'd1,
    ST_BUSY       = 2'd2,
    ST_TURNAROUND = 2'd3
  } state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin search: first requester above last_owner, wrapping.
module rr_picker
  import pci_arb_pkg::*;
#(
  parameter int unsigned NUM_DEV = 4
) (
  input  logic [NUM_DEV-1:0] req,
  input  logic [OWNER_W-1:0] last_owner,
  output logic               found,
  output logic [OWNER_W-1:0] winner
);

  localparam int unsigned IDX_W = (NUM_DEV > 1) ? $clog2(NUM_DEV) : 1;

  always_comb begin
    int unsigned idx;
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int unsigned k = 1; k <= NUM_DEV; k++) begin
      idx = 32'(last_owner) + k;
      if (idx >= NUM_DEV) idx = idx - NUM_DEV;
      if (!found && req[IDX_W'(idx)]) begin
        found  = 1'b1;
        winner = OWNER_W'(idx);
      end
    end
  end

endmodule

// File: rtl/pci_arbiter.sv
// Round-robin PCI bus arbiter with grant timeout and turnaround cycle.
// Optional bus parking when built with PCI_ARB_PARK_EN defined.
module pci_arbiter
  import pci_arb_pkg::*;
#(
  parameter int unsigned NUM_DEV     = 4,
  parameter int unsigned GNT_TIMEOUT = DEF_GNT_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_DEV-1:0] request,
  input  logic               iframe,
  input  logic               iready,
  output logic [NUM_DEV-1:0] grant,
  output logic [OWNER_W-1:0] owner,
  output logic               bus_busy,
  output logic               timeout_err
);

  localparam int unsigned IDX_W = (NUM_DEV > 1) ? $clog2(NUM_DEV) : 1;
  localparam int unsigned CNT_W = $clog2(GNT_TIMEOUT + 1);

  state_t             state, state_d;
  logic [NUM_DEV-1:0] grant_d;
  logic [OWNER_W-1:0] owner_d, last_owner, last_d, winner;
  logic               busy_d, terr_d, found, bus_idle;
  logic [CNT_W-1:0]   cnt, cnt_d, cnt_inc;
  logic [NUM_DEV-1:0] req_act;

  assign bus_idle = iframe & iready;
  assign req_act  = ~request;
  assign cnt_inc  = (cnt == CNT_W'(GNT_TIMEOUT)) ? cnt : cnt + CNT_W'(1);

  rr_picker #(.NUM_DEV(NUM_DEV)) u_picker (
    .req        (req_act),
    .last_owner (last_owner),
    .found      (found),
    .winner     (winner)
  );

`ifdef PCI_ARB_PARK_EN
  logic parked;
  assign parked = (grant != '1);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      grant       <= '1;
      owner       <= '0;
      bus_busy    <= 1'b0;
      timeout_err <= 1'b0;
      cnt         <= '0;
      last_owner  <= OWNER_W'(NUM_DEV - 1);
    end else begin
      state       <= state_d;
      grant       <= grant_d;
      owner       <= owner_d;
      bus_busy    <= busy_d;
      timeout_err <= terr_d;
      cnt         <= cnt_d;
      last_owner  <= last_d;
    end
  end

  always_comb begin
    state_d = state;
    grant_d = grant;
    owner_d = owner;
    busy_d  = bus_busy;
    terr_d  = 1'b0;
    cnt_d   = cnt;
    last_d  = last_owner;
    case (state)
      ST_IDLE: begin
        busy_d = 1'b0;
`ifdef PCI_ARB_PARK_EN
        if (parked && !iframe) begin
          // Parked device started a transaction without arbitrating.
          state_d = ST_BUSY;
          grant_d = '1;
          busy_d  = 1'b1;
          owner_d = last_owner;
        end else if (found && bus_idle) begin
          if (parked && winner != last_owner) begin
            grant_d = '1;
          end else begin
            grant_d = '1;
            grant_d[IDX_W'(winner)] = 1'b0;
            owner_d = winner;
            cnt_d   = '0;
            state_d = ST_GRANTED;
          end
        end else if (!found) begin
          grant_d = '1;
          grant_d[IDX_W'(last_owner)] = 1'b0;
          owner_d = last_owner;
        end
`else
        grant_d = '1;
        if (found && bus_idle) begin
          grant_d[IDX_W'(winner)] = 1'b0;
          owner_d = winner;
          cnt_d   = '0;
          state_d = ST_GRANTED;
        end
`endif
      end
      ST_GRANTED: begin
        if (!iframe) begin
          state_d = ST_BUSY;
          busy_d  = 1'b1;
          grant_d = '1;
          last_d  = owner;
        end else if (!req_act[IDX_W'(owner)]) begin
          state_d = ST_IDLE;
          grant_d = '1;
          last_d  = owner;
        end else if (cnt_inc == CNT_W'(GNT_TIMEOUT)) begin
          state_d = ST_IDLE;
          grant_d = '1;
          terr_d  = 1'b1;
          last_d  = owner;
          cnt_d   = cnt_inc;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_BUSY: begin
        if (bus_idle) begin
          state_d = ST_TURNAROUND;
          busy_d  = 1'b0;
        end
      end
      ST_TURNAROUND: begin
        grant_d = '1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_pci_arbiter.sv
// Directed table-driven bench for pci_arbiter (NUM_DEV=4, GNT_TIMEOUT=16).
module tb_pci_arbiter;

`ifdef PCI_ARB_PARK_EN
  localparam bit PARK = 1'b1;
`else
  localparam bit PARK = 1'b0;
`endif

  typedef struct {
    logic [3:0] request;
    logic       iframe;
    logic       iready;
    logic [3:0] grant;
    logic [2:0] owner;
    logic       busy;
    logic       terr;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] request;
  logic       iframe;
  logic       iready;
  logic [3:0] grant;
  logic [2:0] owner;
  logic       bus_busy;
  logic       timeout_err;

  int n_cmp = 0;
  int n_err = 0;
  vec_t vq[$];

  pci_arbiter #(.NUM_DEV(4), .GNT_TIMEOUT(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .request     (request),
    .iframe      (iframe),
    .iready      (iready),
    .grant       (grant),
    .owner       (owner),
    .bus_busy    (bus_busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    request = 4'b1111;
    iframe  = 1'b1;
    iready  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic vec_t mk(input logic [3:0] r, input logic f, input logic rd,
                              input logic [3:0] g, input logic [2:0] o,
                              input logic b, input logic t);
    vec_t v;
    v.request = r; v.iframe = f; v.iready = rd;
    v.grant = g; v.owner = o; v.busy = b; v.terr = t;
    return v;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values while rst_n is held low
    rst_n = 1'b0; request = 4'b1111; iframe = 1'b1; iready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst grant", 8'(grant), 8'h0F);
    check("rst owner", 8'(owner), 8'h00);
    check("rst busy",  8'(bus_busy), 8'h00);
    check("rst terr",  8'(timeout_err), 8'h00);

    // Device 0 wins first after reset
    request = 4'b1010;
    rst_n   = 1'b1;
    tick(); tick();
    check("first grant", 8'(grant), 8'h0E);
    check("first owner", 8'(owner), 8'h00);

    // Round-robin through all four devices with full transactions
    vq.push_back(mk(4'b0000, 1'b1, 1'b1, 4'b1110, 3'd0, 1'b0, 1'b0));
    for (int k = 0; k < 4; k++) begin
      int nk;
      logic [3:0] rb, gn;
      nk = (k + 1) % 4;
      rb = (k == 2) ? 4'b1111 : 4'b0000;
      gn = ~(4'b0001 << nk);
      vq.push_back(mk(4'b0000, 1'b0, 1'b1, 4'b1111, 3'(k),  1'b1, 1'b0));
      vq.push_back(mk(rb,      1'b1, 1'b0, 4'b1111, 3'(k),  1'b1, 1'b0));
      vq.push_back(mk(rb,      1'b1, 1'b1, 4'b1111, 3'(k),  1'b0, 1'b0));
      vq.push_back(mk(4'b0000, 1'b1, 1'b1, 4'b1111, 3'(k),  1'b0, 1'b0));
      vq.push_back(mk(4'b0000, 1'b1, 1'b1, gn,      3'(nk), 1'b0, 1'b0));
    end
    do_reset();
    foreach (vq[i]) begin
      request = vq[i].request;
      iframe  = vq[i].iframe;
      iready  = vq[i].iready;
      tick();
      check($sformatf("vec%0d grant", i), 8'(grant),       8'(vq[i].grant));
      check($sformatf("vec%0d owner", i), 8'(owner),       8'(vq[i].owner));
      check($sformatf("vec%0d busy", i),  8'(bus_busy),    8'(vq[i].busy));
      check($sformatf("vec%0d terr", i),  8'(timeout_err), 8'(vq[i].terr));
    end
    iframe = 1'b1; iready = 1'b1;

    // Grant timeout: device 2 never drives iframe
    do_reset();
    request = 4'b1011;
    tick();
    check("to grant", 8'(grant), 8'h0B);
    check("to owner", 8'(owner), 8'h02);
    for (int i = 1; i <= 15; i++) begin
      tick();
      check($sformatf("to hold%0d grant", i), 8'(grant), 8'h0B);
      check($sformatf("to hold%0d terr", i), 8'(timeout_err), 8'h00);
    end
    request = 4'b0011;
    tick();
    check("to release grant", 8'(grant), 8'h0F);
    check("to pulse", 8'(timeout_err), 8'h01);
    tick();
    check("to next grant", 8'(grant), 8'h07);
    check("to next owner", 8'(owner), 8'h03);
    check("to pulse end", 8'(timeout_err), 8'h00);

    // Device 1 withdraws its request before iframe
    do_reset();
    request = 4'b1101;
    tick();
    check("drop grant", 8'(grant), 8'h0D);
    request = 4'b1111;
    tick();
    check("drop release", 8'(grant), 8'h0F);
    check("drop terr", 8'(timeout_err), 8'h00);
    tick();
    check("drop idle", 8'(grant), PARK ? 8'h0D : 8'h0F);
    request = 4'b1101;
    tick();
    check("regrant grant", 8'(grant), 8'h0D);
    check("regrant owner", 8'(owner), 8'h01);

    // Asynchronous reset during a busy transaction
    do_reset();
    request = 4'b1101;
    tick();
    iframe = 1'b0;
    tick();
    check("busy before rst", 8'(bus_busy), 8'h01);
    iframe = 1'b1; iready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst grant", 8'(grant), 8'h0F);
    check("async rst busy",  8'(bus_busy), 8'h00);
    check("async rst owner", 8'(owner), 8'h00);
    iready = 1'b1;

`ifdef PCI_ARB_PARK_EN
    // Parking on last owner and release before a new grant
    do_reset();
    tick();
    check("park grant", 8'(grant), 8'h07);
    check("park owner", 8'(owner), 8'h03);
    tick();
    check("park hold", 8'(grant), 8'h07);
    request = 4'b1110;
    tick();
    check("park drop", 8'(grant), 8'h0F);
    tick();
    check("park new grant", 8'(grant), 8'h0E);
    check("park new owner", 8'(owner), 8'h00);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
